digit_serial_adder: RTL and testbench

DIGIT_SERIAL_ADDER -- requirements
Module: digit_serial_adder

---
 rtl/digit_serial_pkg.sv | 5 +
 rtl/add2_slice.sv | 12 +
 rtl/digit_serial_adder.sv | 83 ++++++++
 tb/tb_digit_serial_adder.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/digit_serial_pkg.sv
// digit_serial_pkg: shared FSM state encoding and digit size for the digit-serial adder
package digit_serial_pkg;
    localparam int DIGIT_BITS = 2;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/add2_slice.sv
// add2_slice: combinational 2-bit full-adder slice
module add2_slice
    import digit_serial_pkg::*;
(
    input  logic [DIGIT_BITS-1:0] a,
    input  logic [DIGIT_BITS-1:0] b,
    input  logic                  cin,
    output logic [DIGIT_BITS-1:0] sum,
    output logic                  cout
);
    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{DIGIT_BITS{1'b0}}, cin};
endmodule

// File: rtl/digit_serial_adder.sv
// digit_serial_adder: adds two WIDTH-bit operands two bits per cycle, LSB digit first, valid/ready on both sides
module digit_serial_adder
    import digit_serial_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             busy
);
    localparam int DIGITS = WIDTH / DIGIT_BITS;
    localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    state_t state, next;
    logic [WIDTH-1:0] a_reg, b_reg, res;
    logic [CW-1:0] cnt;
    logic carry, slice_cout, last;
    logic [DIGIT_BITS-1:0] slice_sum;
    logic [WIDTH+DIGIT_BITS-1:0] res_shift;

    add2_slice u_slice (
        .a(a_reg[DIGIT_BITS-1:0]),
        .b(b_reg[DIGIT_BITS-1:0]),
        .cin(carry),
        .sum(slice_sum),
        .cout(slice_cout)
    );

    assign last = cnt == CW'(DIGITS - 1);
    // New digit enters at the MSB end so the LSB digit lands at bit 0 after the final shift
    assign res_shift = {slice_sum, res};

    always_comb begin
        next = state;
        case (state)
            IDLE: next = in_valid ? RUN : IDLE;
            RUN: next = last ? DONE : RUN;
            DONE: next = out_ready ? IDLE : DONE;
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            a_reg <= '0;
            b_reg <= '0;
            res <= '0;
            carry <= 1'b0;
            cnt <= '0;
        end else begin
            state <= next;
            if (state == IDLE && in_valid) begin
                a_reg <= in_a;
                b_reg <= in_b;
                carry <= in_cin;
                cnt <= '0;
            end
            if (state == RUN) begin
                a_reg <= a_reg >> DIGIT_BITS;
                b_reg <= b_reg >> DIGIT_BITS;
                res <= res_shift[WIDTH+DIGIT_BITS-1:DIGIT_BITS];
                carry <= slice_cout;
                cnt <= last ? cnt : cnt + 1'b1;
            end
        end
    end

    assign in_ready = state == IDLE;
    assign out_valid = state == DONE;
    assign busy = state != IDLE;
    assign out_sum = res;
    assign out_cout = carry;
endmodule

// File: tb/tb_digit_serial_adder.sv
// tb_digit_serial_adder: scoreboard bench for the digit-serial adder at WIDTH=8 and WIDTH=2
module tb_digit_serial_adder;
    localparam int W = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;
    logic in_valid = 1'b0, in_cin = 1'b0, out_ready = 1'b0;
    logic [W-1:0] in_a = '0, in_b = '0;
    logic in_ready, out_valid, out_cout, busy;
    logic [W-1:0] out_sum;

    logic in_valid2 = 1'b0, in_cin2 = 1'b0, out_ready2 = 1'b0;
    logic [1:0] in_a2 = '0, in_b2 = '0;
    logic in_ready2, out_valid2, out_cout2, busy2;
    logic [1:0] out_sum2;

    digit_serial_adder #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .out_valid(out_valid),
        .out_ready(out_ready), .out_sum(out_sum), .out_cout(out_cout), .busy(busy)
    );

    digit_serial_adder #(.WIDTH(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
        .in_a(in_a2), .in_b(in_b2), .in_cin(in_cin2), .out_valid(out_valid2),
        .out_ready(out_ready2), .out_sum(out_sum2), .out_cout(out_cout2), .busy(busy2)
    );

    int errors = 0, checks = 0, cyc = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [W:0] res;
        int acc;
    } exp_t;
    exp_t sb[$];
    exp_t e;
    bit b2b = 0;
    int last_acc = -1;
    logic prev_ov = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: push the reference sum on accept, pop and compare on the result handshake
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
        end else begin
            if (out_valid && !prev_ov) begin
                if (sb.size() == 0) check("unexpected_out", 1, 0);
                else check("latency", cyc - sb[0].acc, W / 2 + 1);
            end
            if (out_valid && out_ready && sb.size() > 0) begin
                e = sb.pop_front();
                check("sb_sum", {24'b0, out_sum}, {24'b0, e.res[W-1:0]});
                check("sb_cout", {31'b0, out_cout}, {31'b0, e.res[W]});
            end
            if (in_valid && in_ready) begin
                if (b2b && last_acc >= 0) check("spacing", cyc - last_acc, W / 2 + 2);
                last_acc = cyc;
                sb.push_back('{res: {1'b0, in_a} + {1'b0, in_b} + {{W{1'b0}}, in_cin}, acc: cyc});
            end
        end
        prev_ov = out_valid && !rst;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string tag);
        for (int i = 0; i < 20 && !out_valid; i++) tick();
        check(tag, {31'b0, out_valid}, 1);
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 20 && !in_ready; i++) tick();
        check("ready_timeout", {31'b0, in_ready}, 1);
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                          input logic [W-1:0] exp_sum, input logic exp_cout);
        wait_ready();
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        in_cin = cin;
        tick();
        in_valid = 1'b0;
        wait_valid("op_timeout");
        check("op_sum", {24'b0, out_sum}, {24'b0, exp_sum});
        check("op_cout", {31'b0, out_cout}, {31'b0, exp_cout});
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        logic [W:0] r;
        tick();
        tick();
        check("rst_out_valid", {31'b0, out_valid}, 0);
        check("rst_in_ready", {31'b0, in_ready}, 1);
        check("rst_busy", {31'b0, busy}, 0);
        check("rst_sum", {24'b0, out_sum}, 0);
        check("rst_cout", {31'b0, out_cout}, 0);
        check("rst2_in_ready", {31'b0, in_ready2}, 1);
        check("rst2_sum", {30'b0, out_sum2}, 0);
        rst = 1'b0;
        tick();

        run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
        run_op(8'h5A, 8'hA5, 1'b1, 8'h00, 1'b1);
        run_op(8'h12, 8'h34, 1'b0, 8'h46, 1'b0);

        // Stalled result: outputs hold and a new request is ignored
        wait_ready();
        in_valid = 1'b1;
        in_a = 8'h77;
        in_b = 8'h11;
        in_cin = 1'b0;
        tick();
        in_valid = 1'b0;
        wait_valid("stall_timeout");
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            in_a = 8'hC3;
            in_b = 8'h3C;
            tick();
            check("stall_valid", {31'b0, out_valid}, 1);
            check("stall_sum", {24'b0, out_sum}, 32'h88);
            check("stall_cout", {31'b0, out_cout}, 0);
            check("stall_in_ready", {31'b0, in_ready}, 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("stall_idle_ready", {31'b0, in_ready}, 1);
        check("stall_idle_valid", {31'b0, out_valid}, 0);
        check("stall_idle_busy", {31'b0, busy}, 0);

        // Reset in the second RUN cycle, with a competing request
        in_valid = 1'b1;
        in_a = 8'h40;
        in_b = 8'h40;
        tick();
        in_valid = 1'b0;
        tick();
        check("mid_busy", {31'b0, busy}, 1);
        rst = 1'b1;
        in_valid = 1'b1;
        tick();
        rst = 1'b0;
        in_valid = 1'b0;
        check("mrst_out_valid", {31'b0, out_valid}, 0);
        check("mrst_in_ready", {31'b0, in_ready}, 1);
        check("mrst_busy", {31'b0, busy}, 0);
        run_op(8'h03, 8'h01, 1'b0, 8'h04, 1'b0);

        for (int i = 0; i < 4; i++) begin
            in_a = W'($urandom);
            in_b = W'($urandom);
            in_cin = 1'($urandom);
            r = {1'b0, in_a} + {1'b0, in_b} + {{W{1'b0}}, in_cin};
            run_op(in_a, in_b, in_cin, r[W-1:0], r[W]);
        end

        // Back-to-back: in_valid and out_ready held high
        b2b = 1;
        last_acc = -1;
        out_ready = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 4 * (W / 2 + 2) + 1; i++) begin
            in_a = W'($urandom);
            in_b = W'($urandom);
            in_cin = 1'($urandom);
            tick();
        end
        in_valid = 1'b0;
        for (int i = 0; i < 20 && busy; i++) tick();
        check("b2b_drain", {31'b0, busy}, 0);
        out_ready = 1'b0;
        b2b = 0;
        check("sb_empty", sb.size(), 0);

        // WIDTH=2: one RUN cycle
        in_valid2 = 1'b1;
        in_a2 = 2'd3;
        in_b2 = 2'd3;
        in_cin2 = 1'b1;
        tick();
        in_valid2 = 1'b0;
        check("w2_run_valid", {31'b0, out_valid2}, 0);
        check("w2_run_busy", {31'b0, busy2}, 1);
        tick();
        check("w2_valid", {31'b0, out_valid2}, 1);
        check("w2_sum", {30'b0, out_sum2}, 3);
        check("w2_cout", {31'b0, out_cout2}, 1);
        out_ready2 = 1'b1;
        tick();
        out_ready2 = 1'b0;
        check("w2_idle", {31'b0, in_ready2}, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
